// File: rtl/sr_dmem_arbiter_pkg.sv
// Shared types and helpers for the sr_dmem_arbiter data-memory arbiter.
// Align encodings and port indices match the sr_cpu load/store path.
package sr_dmem_arbiter_pkg;

    localparam logic [1:0] ALIGN_WORD = 2'b00;
    localparam logic [1:0] ALIGN_HALF = 2'b01;
    localparam logic [1:0] ALIGN_BYTE = 2'b10;

    typedef enum logic {
        DM_P0 = 1'b0,
        DM_P1 = 1'b1
    } port_t;

    typedef struct packed {
        logic       valid;
        port_t      port;
        logic [1:0] align;
        logic [1:0] off;
    } rtag_t;

    // Right-align a memory word for the given size; upper bits come back zero.
    function automatic logic [31:0] lane_extract(input logic [1:0] align,
                                                 input logic [1:0] off,
                                                 input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {off, 3'b000};
        case (align)
            ALIGN_HALF: return {16'h0000, sh[15:0]};
            ALIGN_BYTE: return {24'h000000, sh[7:0]};
            default:    return sh;
        endcase
    endfunction

endpackage

// File: rtl/sr_dmem_lane.sv
// Write-side lane steering: byte enables, shifted store data and misalign detect.
module sr_dmem_lane
    import sr_dmem_arbiter_pkg::*;
(
    input  logic [1:0]  align,
    input  logic [1:0]  offset,
    input  logic [31:0] wd,
    output logic [3:0]  be,
    output logic [31:0] wd_sh,
    output logic        misalign
);

    always_comb begin
        be       = '0;
        misalign = 1'b0;
        wd_sh    = wd << {offset, 3'b000};
        case (align)
            ALIGN_WORD: begin
                be       = 4'b1111;
                misalign = (offset != 2'b00);
            end
            ALIGN_HALF: begin
                be       = 4'b0011 << offset;
                misalign = offset[0];
            end
            ALIGN_BYTE: begin
                be       = 4'b0001 << offset;
            end
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/sr_dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Grants are combinational; load data returns right-aligned one cycle later.
module sr_dmem_arbiter
    import sr_dmem_arbiter_pkg::*;
#(
    parameter int MEM_AW = 6,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [1:0]        p0_align,
    input  logic [1:0]        p1_align,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p0_wd,
    input  logic [31:0]       p1_wd,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_err,
    output logic              p1_err,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       p0_rd,
    output logic [31:0]       p1_rd,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd
);

    port_t       ptr;
    port_t       sel;
    rtag_t       tag;
    logic        any_req;
    logic        sel_we;
    logic [1:0]  sel_align;
    logic [31:0] sel_addr;
    logic [31:0] sel_wd;
    logic [3:0]  be;
    logic [31:0] wd_sh;
    logic        misalign;
    logic [31:0] rd_ext;
    logic [31:0] rd0_q;
    logic [31:0] rd1_q;

    assign any_req = p0_req | p1_req;

    always_comb begin
        if (p0_req && p1_req)
            sel = (RR_EN != 0) ? ptr : DM_P0;
        else if (p1_req)
            sel = DM_P1;
        else
            sel = DM_P0;
    end

    assign sel_we    = (sel == DM_P1) ? p1_we    : p0_we;
    assign sel_align = (sel == DM_P1) ? p1_align : p0_align;
    assign sel_addr  = (sel == DM_P1) ? p1_addr  : p0_addr;
    assign sel_wd    = (sel == DM_P1) ? p1_wd    : p0_wd;

    sr_dmem_lane u_lane (
        .align    (sel_align),
        .offset   (sel_addr[1:0]),
        .wd       (sel_wd),
        .be       (be),
        .wd_sh    (wd_sh),
        .misalign (misalign)
    );

    assign p0_gnt = any_req && (sel == DM_P0);
    assign p1_gnt = any_req && (sel == DM_P1);
    assign p0_err = p0_gnt && misalign;
    assign p1_err = p1_gnt && misalign;

    // A misaligned access is acknowledged but never reaches the memory.
    assign mem_en   = any_req && !misalign;
    assign mem_we   = mem_en && sel_we;
    assign mem_be   = mem_en ? be : '0;
    assign mem_addr = mem_en ? sel_addr[MEM_AW+1:2] : '0;
    assign mem_wd   = mem_en ? wd_sh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= DM_P0;
            tag <= '0;
        end else begin
            if (any_req)
                ptr <= (sel == DM_P0) ? DM_P1 : DM_P0;
            tag.valid <= mem_en && !sel_we;
            tag.port  <= sel;
            tag.align <= sel_align;
            tag.off   <= sel_addr[1:0];
        end
    end

    // rvalid comes straight off the tag register so it lines up with mem_rd.
    assign p0_rvalid = tag.valid && (tag.port == DM_P0);
    assign p1_rvalid = tag.valid && (tag.port == DM_P1);
    assign rd_ext    = lane_extract(tag.align, tag.off, mem_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_q <= '0;
            rd1_q <= '0;
        end else begin
            if (p0_rvalid)
                rd0_q <= rd_ext;
            if (p1_rvalid)
                rd1_q <= rd_ext;
        end
    end

    assign p0_rd = p0_rvalid ? rd_ext : rd0_q;
    assign p1_rd = p1_rvalid ? rd_ext : rd1_q;

endmodule

// File: tb/tb_sr_dmem_arbiter.sv
// Scoreboard bench for sr_dmem_arbiter: directed accesses, contention and reset.
module tb_sr_dmem_arbiter;
    import sr_dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [1:0]  p0_align, p1_align;
    logic [31:0] p0_addr, p1_addr, p0_wd, p1_wd;
    logic        p0_gnt, p1_gnt, p0_err, p1_err, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rd, p1_rd;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic        fp_p0_gnt, fp_p1_gnt, fp_p0_err, fp_p1_err, fp_p0_rvalid, fp_p1_rvalid;
    logic [31:0] fp_p0_rd, fp_p1_rd;
    logic        fp_mem_en, fp_mem_we;
    logic [3:0]  fp_mem_be;
    logic [5:0]  fp_mem_addr;
    logic [31:0] fp_mem_wd;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    logic [31:0] tb_mem [64];

    always #5 clk = ~clk;

    sr_dmem_arbiter #(.MEM_AW(6), .RR_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_align(p0_align), .p1_align(p1_align), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wd(p0_wd), .p1_wd(p1_wd), .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_err(p0_err), .p1_err(p1_err), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rd(p0_rd), .p1_rd(p1_rd), .mem_en(mem_en), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    sr_dmem_arbiter #(.MEM_AW(6), .RR_EN(0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
        .p0_align(p0_align), .p1_align(p1_align), .p0_addr(p0_addr), .p1_addr(p1_addr),
        .p0_wd(p0_wd), .p1_wd(p1_wd), .p0_gnt(fp_p0_gnt), .p1_gnt(fp_p1_gnt),
        .p0_err(fp_p0_err), .p1_err(fp_p1_err), .p0_rvalid(fp_p0_rvalid), .p1_rvalid(fp_p1_rvalid),
        .p0_rd(fp_p0_rd), .p1_rd(fp_p1_rd), .mem_en(fp_mem_en), .mem_we(fp_mem_we),
        .mem_be(fp_mem_be), .mem_addr(fp_mem_addr), .mem_wd(fp_mem_wd), .mem_rd(mem_rd)
    );

    // Behavioural single-port memory macro driven by the RR instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
            end else begin
                mem_rd <= tb_mem[mem_addr];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic mon_check(input int port, input logic [31:0] rd);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rvalid port=%0d actual=%h required=none", port, rd);
        end else begin
            e = sbq.pop_front();
            chk("rvalid_port", port, e.port);
            chk("rd_data", rd, e.data);
            chk("rvalid_latency", cyc, e.cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (p0_rvalid) mon_check(0, p0_rd);
            if (p1_rvalid) mon_check(1, p1_rd);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        @(negedge clk);
        p0_req = 1'b0;
        p1_req = 1'b0;
    endtask

    task automatic do_access(input int p, input logic we, input logic [1:0] al,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic eerr, input logic [31:0] erd);
        @(negedge clk);
        p0_req = (p == 0); p1_req = (p == 1);
        p0_we = we; p1_we = we; p0_align = al; p1_align = al;
        p0_addr = a; p1_addr = a; p0_wd = wd; p1_wd = wd;
        #1;
        chk("gnt", {30'd0, p1_gnt, p0_gnt}, (p == 0) ? 32'd1 : 32'd2);
        chk("err", {30'd0, p1_err, p0_err}, eerr ? ((p == 0) ? 32'd1 : 32'd2) : 32'd0);
        chk("mem_en", {31'd0, mem_en}, {31'd0, !eerr});
        if (!eerr) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, we});
            chk("mem_be", {28'd0, mem_be}, {28'd0, ebe});
            chk("mem_addr", {26'd0, mem_addr}, {26'd0, a[7:2]});
            if (we) chk("mem_wd", mem_wd, ewd);
            else    sbq.push_back('{p, erd, cyc + 1});
        end
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tb_mem[i] = '0;
        mem_rd = '0;
        rst_n = 1'b0;
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_align = ALIGN_WORD; p1_align = ALIGN_WORD;
        p0_addr = '0; p1_addr = '0; p0_wd = '0; p1_wd = '0;
        #12;
        chk("reset_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
        chk("reset_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        chk("reset_p0_rd", p0_rd, 32'd0);
        chk("reset_p1_rd", p1_rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stores and loads, back to back
        do_access(0, 1, ALIGN_WORD, 32'h10,  32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0, 0);
        do_access(1, 1, ALIGN_BYTE, 32'h13,  32'h000000A5, 4'b1000, 32'hA5000000, 0, 0);
        do_access(1, 0, ALIGN_BYTE, 32'h13,  32'h0,        4'b1000, 32'h0, 0, 32'h000000A5);
        do_access(0, 0, ALIGN_HALF, 32'h12,  32'h0,        4'b1100, 32'h0, 0, 32'h0000A5AD);
        do_access(0, 0, ALIGN_WORD, 32'h10,  32'h0,        4'b1111, 32'h0, 0, 32'hA5ADBEEF);
        do_access(1, 0, ALIGN_BYTE, 32'h11,  32'h0,        4'b0010, 32'h0, 0, 32'h000000BE);
        do_access(0, 1, ALIGN_HALF, 32'h116, 32'h00001234, 4'b1100, 32'h12340000, 0, 0);
        do_access(0, 0, ALIGN_WORD, 32'h14,  32'h0,        4'b1111, 32'h0, 0, 32'h12340000);
        idle();
        @(negedge clk);
        chk("p0_rd_hold", p0_rd, 32'h12340000);
        chk("p1_rd_hold", p1_rd, 32'h000000BE);

        // Error cases: no memory access, no rvalid
        do_access(0, 0, ALIGN_HALF, 32'h21, 32'h0, 4'b0000, 32'h0, 1, 0);
        do_access(0, 0, 2'b11,      32'h00, 32'h0, 4'b0000, 32'h0, 1, 0);
        do_access(1, 1, ALIGN_WORD, 32'h12, 32'h0, 4'b0000, 32'h0, 1, 0);
        idle();

        // Contention: p0 word load @0x10, p1 byte load @0x13
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_align = ALIGN_WORD; p0_addr = 32'h10;
        p1_req = 1; p1_we = 0; p1_align = ALIGN_BYTE; p1_addr = 32'h13;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_gnt", {30'd0, p1_gnt, p0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
            chk("fp_gnt", {30'd0, fp_p1_gnt, fp_p0_gnt}, 32'd1);
            sbq.push_back('{i % 2, (i % 2 == 0) ? 32'hA5ADBEEF : 32'h000000A5, cyc + 1});
            @(negedge clk);
        end
        p0_req = 0; p1_req = 0;
        @(negedge clk);

        // Load then reset before its data returns; pointer must favour p0 again
        p0_req = 1; p0_we = 0; p0_align = ALIGN_WORD; p0_addr = 32'h10;
        #1;
        chk("pre_reset_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        p0_req = 0;
        #1;
        chk("reset_kills_rvalid", {31'd0, p0_rvalid}, 32'd0);
        chk("reset_clears_rd", p0_rd, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_rvalid", {31'd0, p0_rvalid}, 32'd0);
        p0_req = 1; p1_req = 1;
        #1;
        chk("post_reset_prio", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        sbq.push_back('{0, 32'hA5ADBEEF, cyc + 1});
        @(negedge clk);
        p0_req = 0; p1_req = 0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
